// File: rtl/alu_rr_scheduler_if.sv
// Requester-side handshake bundle for alu_rr_scheduler.
// master: requesters (req_valid/a/b/op, rsp_ready); slave: scheduler.
interface alu_rr_scheduler_if #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ*2-1:0] req_op;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [N-1:0]         rsp_result;
  logic [3:0]           rsp_flags;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_flags
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_flags
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin share of one registered ALU among NUM_REQ requesters.
// Ports: clk, reset (sync, high), bus (req/rsp handshakes), alu_* (to/from alu), busy.
module alu_rr_scheduler #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_rr_scheduler_if.slave     bus,
  output logic [N-1:0]          alu_a,
  output logic [N-1:0]          alu_b,
  output logic [1:0]            alu_op,
  input  logic [N-1:0]          alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  busy
);
  localparam int W = $clog2(NUM_REQ);
  localparam logic [W:0] NR = (W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [W-1:0] ptr;
  logic [W-1:0] gnt;
  logic [W-1:0] sel;
  logic [W-1:0] ptr_nx;
  logic [W:0]   sum;
  logic [W:0]   inc;
  logic         found;
  logic         accept;

  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [1:0]   op_q;
  logic [N-1:0] res_q;
  logic [3:0]   flg_q;

  logic [N-1:0] a_sel;
  logic [N-1:0] b_sel;
  logic [1:0]   op_sel;

  // First valid port at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= NR) sum = sum - NR;
      if (!found && bus.req_valid[sum[W-1:0]]) begin
        found = 1'b1;
        sel   = sum[W-1:0];
      end
    end
  end

  always_comb begin
    inc    = {1'b0, sel} + 1'b1;
    ptr_nx = (inc == NR) ? '0 : inc[W-1:0];
  end

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == W'(i)) begin
        a_sel  = bus.req_a[i*N +: N];
        b_sel  = bus.req_b[i*N +: N];
        op_sel = bus.req_op[i*2 +: 2];
      end
    end
  end

  assign accept = (state == IDLE) && found;

  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) state_nx = EXEC;
        if (found && !reset) bus.req_ready[sel] = 1'b1;
      end
      EXEC: begin
        state_nx = CAPT;
        busy     = !reset;
      end
      CAPT: begin
        state_nx = RESP;
        busy     = !reset;
      end
      RESP: begin
        busy = !reset;
        if (!reset) bus.rsp_valid[gnt] = 1'b1;
        if (bus.rsp_ready[gnt]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        op_q <= op_sel;
        gnt  <= sel;
        ptr  <= ptr_nx;
      end
      if (state == CAPT) begin
        res_q <= alu_result;
        flg_q <= alu_flags;
      end
    end
  end

  // Operands hold after EXEC until the next accept.
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_op         = op_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flg_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler with a registered ALU model and scoreboard.
// Drives req/rsp via the interface; prints one TB_RESULT line.
module tb_alu_rr_scheduler;
  logic        clk;
  logic        reset;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        busy;

  alu_rr_scheduler_if #(.N(32), .NUM_REQ(4)) bus ();

  alu_rr_scheduler #(.N(32), .NUM_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  typedef struct {
    int          port;
    logic [31:0] res;
    logic [3:0]  fl;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   gnt_port[$];
  int   gnt_cyc[$];
  int   checks;
  int   failures;
  int   cyc;
  bit   rsp_seen;

  function automatic logic [35:0] alu_ref(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  op
  );
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    s = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      alu_result <= '0;
      alu_flags  <= '0;
    end else begin
      {alu_flags, alu_result} <= alu_ref(alu_a, alu_b, alu_op);
    end
  end

  task automatic tick();
    logic [3:0] acc;
    exp_t       e;
    #1;
    acc = bus.req_ready & bus.req_valid;
    if (bus.req_ready != 4'b0) begin
      checks++;
      if ($countones(bus.req_ready) != 1) begin
        failures++;
        $display("FAIL req_ready_onehot got=%b want=one bit", bus.req_ready);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        e.port = i;
        {e.fl, e.res} = alu_ref(bus.req_a[i*32 +: 32],
                                bus.req_b[i*32 +: 32],
                                bus.req_op[i*2 +: 2]);
        e.acc_cyc = cyc;
        sb.push_back(e);
        gnt_port.push_back(i);
        gnt_cyc.push_back(cyc);
      end
    end
    if (bus.rsp_valid != 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got=%b want=0000", bus.rsp_valid);
      end else begin
        if (bus.rsp_valid !== (4'b0001 << sb[0].port)) begin
          failures++;
          $display("FAIL rsp_port got=%b want port %0d",
                   bus.rsp_valid, sb[0].port);
        end
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          checks++;
          if (cyc - sb[0].acc_cyc != 3) begin
            failures++;
            $display("FAIL rsp_latency got=%0d want=3",
                     cyc - sb[0].acc_cyc);
          end
        end
        if ((bus.rsp_valid & bus.rsp_ready) != 4'b0) begin
          checks++;
          if (bus.rsp_result !== sb[0].res || bus.rsp_flags !== sb[0].fl) begin
            failures++;
            $display("FAIL rsp_data got=%h/%b want=%h/%b",
                     bus.rsp_result, bus.rsp_flags, sb[0].res, sb[0].fl);
          end
          void'(sb.pop_front());
          rsp_seen = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op);
    bus.req_a[p*32 +: 32] = a;
    bus.req_b[p*32 +: 32] = b;
    bus.req_op[p*2 +: 2]  = op;
    bus.req_valid[p]      = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    sb.delete();
    rsp_seen = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want=0", sb.size());
    end
  endtask

  task automatic wait_accept(input int p, input int budget, output int c);
    int n0;
    n0 = gnt_port.size();
    c  = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (gnt_port.size() > n0) break;
    end
    checks++;
    if (gnt_port.size() == n0) begin
      failures++;
      $display("FAIL accept_timeout port=%0d got none want accept", p);
    end else begin
      c = gnt_cyc[n0];
      if (gnt_port[n0] != p) begin
        failures++;
        $display("FAIL grant_port got=%0d want=%0d", gnt_port[n0], p);
      end
      bus.req_valid[p] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int p, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (bus.rsp_valid[p]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rsp_timeout port=%0d got none want rsp_valid", p);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    for (int i = 0; i < 4; i++)
      set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
    repeat (2) tick();
    #1;
    checks += 8;
    if (bus.req_ready !== 4'b0) begin
      failures++;
      $display("FAIL rst_req_ready got=%b want=0000", bus.req_ready);
    end
    if (bus.rsp_valid !== 4'b0) begin
      failures++;
      $display("FAIL rst_rsp_valid got=%b want=0000", bus.rsp_valid);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    if (alu_a !== 32'd0) begin
      failures++;
      $display("FAIL rst_alu_a got=%h want=0", alu_a);
    end
    if (alu_b !== 32'd0) begin
      failures++;
      $display("FAIL rst_alu_b got=%h want=0", alu_b);
    end
    if (alu_op !== 2'd0) begin
      failures++;
      $display("FAIL rst_alu_op got=%h want=0", alu_op);
    end
    if (bus.rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL rst_rsp_result got=%h want=0", bus.rsp_result);
    end
    if (bus.rsp_flags !== 4'd0) begin
      failures++;
      $display("FAIL rst_rsp_flags got=%b want=0", bus.rsp_flags);
    end
    reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant got=%b want=0001", bus.req_ready);
    end
    tick();
    drain(40);
  endtask

  task automatic test_add();
    int c;
    bus.rsp_ready = '1;
    set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 2'd0);
    wait_accept(0, 10, c);
    wait_rsp(0, 10);
    checks += 3;
    if (cyc - c != 3) begin
      failures++;
      $display("FAIL add_latency got=%0d want=3", cyc - c);
    end
    if (bus.rsp_result !== 32'h8000_0000) begin
      failures++;
      $display("FAIL add_result got=%h want=80000000", bus.rsp_result);
    end
    if (bus.rsp_flags !== 4'b0101) begin
      failures++;
      $display("FAIL add_flags got=%b want=0101", bus.rsp_flags);
    end
    tick();
    drain(20);
  endtask

  task automatic test_round_robin();
    int n0;
    do_reset(2);
    n0 = gnt_port.size();
    for (int i = 0; i < 4; i++)
      set_req(i, 32'(i * 17 + 3), 32'(i + 100), 2'(i));
    bus.rsp_ready = '1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (gnt_port.size() >= n0 + 5) break;
    end
    bus.req_valid = '0;
    checks++;
    if (gnt_port.size() < n0 + 5) begin
      failures++;
      $display("FAIL rr_timeout got=%0d want=5 grants", gnt_port.size() - n0);
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (gnt_port[n0+j] != j % 4) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=%0d want=%0d",
                   j, gnt_port[n0+j], j % 4);
        end
      end
      for (int j = 1; j < 5; j++) begin
        checks++;
        if (gnt_cyc[n0+j] - gnt_cyc[n0+j-1] != 4) begin
          failures++;
          $display("FAIL rr_spacing idx=%0d got=%0d want=4",
                   j, gnt_cyc[n0+j] - gnt_cyc[n0+j-1]);
        end
      end
    end
    drain(40);
  endtask

  task automatic test_hold();
    int c;
    bus.rsp_ready = 4'b1011;
    set_req(2, 32'd0, 32'd1, 2'd1);
    set_req(0, 32'd9, 32'd4, 2'd0);
    wait_accept(2, 10, c);
    wait_rsp(2, 10);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks += 2;
      if (bus.rsp_valid !== 4'b0100) begin
        failures++;
        $display("FAIL hold_rsp_valid cyc=%0d got=%b want=0100",
                 k, bus.rsp_valid);
      end
      if (bus.req_ready !== 4'b0) begin
        failures++;
        $display("FAIL hold_req_ready cyc=%0d got=%b want=0000",
                 k, bus.req_ready);
      end
      tick();
    end
    checks += 2;
    if (bus.rsp_result !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL hold_result got=%h want=ffffffff", bus.rsp_result);
    end
    if (bus.rsp_flags !== 4'b0110) begin
      failures++;
      $display("FAIL hold_flags got=%b want=0110", bus.rsp_flags);
    end
    bus.rsp_ready[2] = 1'b1;
    tick();
    tick();
    drain(40);
  endtask

  task automatic test_reset_mid();
    int c;
    bus.rsp_ready = '1;
    set_req(1, 32'd11, 32'd22, 2'd0);
    wait_accept(1, 10, c);
    tick();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    rsp_seen = 1'b0;
    set_req(0, 32'd1, 32'd2, 2'd3);
    set_req(2, 32'd3, 32'd4, 2'd2);
    #1;
    checks += 3;
    if (bus.rsp_valid !== 4'b0) begin
      failures++;
      $display("FAIL mid_rsp_valid got=%b want=0000", bus.rsp_valid);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle got busy=%b want=0", busy);
    end
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_ptr got=%b want=0001", bus.req_ready);
    end
    tick();
    drain(40);
  endtask

  task automatic test_wrap();
    int c;
    bus.rsp_ready = '1;
    set_req(3, 32'd5, 32'd5, 2'd1);
    wait_accept(3, 10, c);
    set_req(0, 32'h0000_F0F0, 32'h0000_0F0F, 2'd2);
    set_req(1, 32'd7, 32'd8, 2'd3);
    wait_rsp(3, 10);
    checks += 2;
    if (bus.rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL sub_eq_result got=%h want=0", bus.rsp_result);
    end
    if (bus.rsp_flags !== 4'b1000) begin
      failures++;
      $display("FAIL sub_eq_flags got=%b want=1000", bus.rsp_flags);
    end
    wait_accept(0, 10, c);
    bus.req_valid[1] = 1'b0;
    wait_rsp(0, 10);
    checks += 2;
    if (bus.rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL and_result got=%h want=0", bus.rsp_result);
    end
    if (bus.rsp_flags !== 4'b1000) begin
      failures++;
      $display("FAIL and_flags got=%b want=1000", bus.rsp_flags);
    end
    tick();
    drain(20);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    rsp_seen      = 1'b0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '0;
    test_reset();
    test_add();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
